// File: rtl/cpu_pkg.sv
// Shared types for the CPU control sequencer.
// Defines opcodes, sequencer states, instruction classes and strobe bundle.
package cpu_pkg;

  localparam int OP_W = 5;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_ROR  = 5'b00111;
  localparam opcode_t OP_ROL  = 5'b01000;
  localparam opcode_t OP_SHR  = 5'b01001;
  localparam opcode_t OP_SHRA = 5'b01010;
  localparam opcode_t OP_SHL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_MUL  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BRX  = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_JAL  = 5'b10101;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT, PAUSE
  } state_t;

  typedef struct packed {
    logic ralu;
    logic ialu;
    logic muldiv;
    logic unary;
    logic mem;
    logic br;
    logic jmp;
    logic io;
    logic hilo;
    logic nop;
    logic halt;
    logic illegal;
  } opclass_t;

  typedef struct packed {
    logic pcOut;
    logic pcIn;
    logic incPc;
    logic marIn;
    logic mdrIn;
    logic mdrOut;
    logic mdrRead;
    logic ramWrite;
    logic irIn;
    logic ryIn;
    logic rzInLo;
    logic rzInHi;
    logic rzOutLo;
    logic rzOutHi;
    logic hiIn;
    logic loIn;
    logic hiOut;
    logic loOut;
    logic gra;
    logic grb;
    logic grc;
    logic rIn;
    logic rOut;
    logic baOut;
    logic rcOut;
    logic conIn;
    logic inPortOut;
    logic outPortIn;
  } strobe_t;

  function automatic int waitW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/op_decode.sv
// Opcode to instruction-class one-hot decoder.
// Opcodes 11100..11111 fall through to the illegal class.
module op_decode
  import cpu_pkg::*;
(
  input  opcode_t  op,
  output opclass_t cls
);

  always_comb begin
    cls = '0;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
        cls.ralu = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:
        cls.ialu = 1'b1;
      OP_MUL, OP_DIV:
        cls.muldiv = 1'b1;
      OP_NEG, OP_NOT:
        cls.unary = 1'b1;
      OP_LD, OP_LDI, OP_ST:
        cls.mem = 1'b1;
      OP_BRX:
        cls.br = 1'b1;
      OP_JR, OP_JAL:
        cls.jmp = 1'b1;
      OP_IN, OP_OUT:
        cls.io = 1'b1;
      OP_MFHI, OP_MFLO:
        cls.hilo = 1'b1;
      OP_NOP:
        cls.nop = 1'b1;
      OP_HALT:
        cls.halt = 1'b1;
      default:
        cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute control sequencer for the 32-bit CPU.
// Define SINGLE_STEP_EN to add the step input and the PAUSE state.
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        CON,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        RAMwrite,
  output logic        IRin,
  output logic        RYin,
  output logic        RZinLo,
  output logic        RZinHi,
  output logic        RZoutLo,
  output logic        RZoutHi,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        RCout,
  output logic        CONin,
  output logic        InPortOut,
  output logic        OutPortIn,
  output logic        halted,
  output logic        illegal
);

  localparam int CW = waitW(MEM_WAIT);

  state_t   state, nxt, endNxt;
  logic [CW-1:0] waitCnt;
  logic     memState, memDone;
  opcode_t  op;
  opclass_t cls;
  strobe_t  s;
  logic     unusedIrBits;

  assign op = IR[31:27];
  assign unusedIrBits = ^IR[26:0];

  op_decode uDec (
    .op  (op),
    .cls (cls)
  );

`ifdef SINGLE_STEP_EN
  logic stepQ, stepRise;
  assign stepRise = step & ~stepQ;
  assign endNxt   = run ? PAUSE : IDLE;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) stepQ <= 1'b0;
    else       stepQ <= step;
  end
`else
  assign endNxt = run ? T0 : IDLE;
`endif

  // Memory steps hold their state until MEM_WAIT cycles have elapsed
  assign memState = (state == T1)
                  | ((state == T6) & (op == OP_LD))
                  | ((state == T7) & (op == OP_ST));
  assign memDone  = (waitCnt == CW'(MEM_WAIT - 1));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      waitCnt <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= nxt;
      waitCnt <= (memState && !memDone) ? waitCnt + CW'(1) : '0;
      if (state == T3 && cls.illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    s   = '0;
    nxt = state;
    unique case (state)
      IDLE: if (run) nxt = T0;
      T0: begin
        s.pcOut = 1'b1; s.marIn = 1'b1;
        s.incPc = 1'b1; s.rzInLo = 1'b1;
        nxt = T1;
      end
      T1: begin
        s.rzOutLo = 1'b1; s.pcIn = 1'b1;
        s.mdrRead = 1'b1; s.mdrIn = 1'b1;
        if (memDone) nxt = T2;
      end
      T2: begin
        s.mdrOut = 1'b1; s.irIn = 1'b1;
        nxt = T3;
      end
      T3: begin
        unique case (1'b1)
          cls.ralu, cls.ialu: begin
            s.grb = 1'b1; s.rOut = 1'b1; s.ryIn = 1'b1;
            nxt = T4;
          end
          cls.muldiv: begin
            s.gra = 1'b1; s.rOut = 1'b1; s.ryIn = 1'b1;
            nxt = T4;
          end
          cls.unary: begin
            s.grb = 1'b1; s.rOut = 1'b1; s.rzInLo = 1'b1;
            nxt = T4;
          end
          cls.mem: begin
            s.grb = 1'b1; s.baOut = 1'b1; s.ryIn = 1'b1;
            nxt = T4;
          end
          cls.br: begin
            s.gra = 1'b1; s.rOut = 1'b1; s.conIn = 1'b1;
            nxt = T4;
          end
          cls.jmp: begin
            if (op == OP_JR) begin
              s.gra = 1'b1; s.rOut = 1'b1; s.pcIn = 1'b1;
              nxt = endNxt;
            end else begin
              s.pcOut = 1'b1; s.grb = 1'b1; s.rIn = 1'b1;
              nxt = T4;
            end
          end
          cls.io: begin
            s.gra = 1'b1;
            if (op == OP_IN) begin
              s.inPortOut = 1'b1; s.rIn = 1'b1;
            end else begin
              s.rOut = 1'b1; s.outPortIn = 1'b1;
            end
            nxt = endNxt;
          end
          cls.hilo: begin
            s.hiOut = (op == OP_MFHI);
            s.loOut = (op == OP_MFLO);
            s.gra = 1'b1; s.rIn = 1'b1;
            nxt = endNxt;
          end
          cls.nop: nxt = endNxt;
          cls.halt, cls.illegal: nxt = HALT;
          default: nxt = HALT;
        endcase
      end
      T4: begin
        unique case (1'b1)
          cls.ralu: begin
            s.grc = 1'b1; s.rOut = 1'b1; s.rzInLo = 1'b1;
            nxt = T5;
          end
          cls.ialu, cls.mem: begin
            s.rcOut = 1'b1; s.rzInLo = 1'b1;
            nxt = T5;
          end
          cls.muldiv: begin
            s.grb = 1'b1; s.rOut = 1'b1;
            s.rzInLo = 1'b1; s.rzInHi = 1'b1;
            nxt = T5;
          end
          cls.unary: begin
            s.rzOutLo = 1'b1; s.gra = 1'b1; s.rIn = 1'b1;
            nxt = endNxt;
          end
          cls.br: begin
            s.pcOut = 1'b1; s.ryIn = 1'b1;
            nxt = T5;
          end
          cls.jmp: begin
            s.gra = 1'b1; s.rOut = 1'b1; s.pcIn = 1'b1;
            nxt = endNxt;
          end
          default: nxt = IDLE;
        endcase
      end
      T5: begin
        unique case (1'b1)
          cls.ralu, cls.ialu: begin
            s.rzOutLo = 1'b1; s.gra = 1'b1; s.rIn = 1'b1;
            nxt = endNxt;
          end
          cls.muldiv: begin
            s.rzOutLo = 1'b1; s.loIn = 1'b1;
            nxt = T6;
          end
          cls.mem: begin
            s.rzOutLo = 1'b1;
            if (op == OP_LDI) begin
              s.gra = 1'b1; s.rIn = 1'b1;
              nxt = endNxt;
            end else begin
              s.marIn = 1'b1;
              nxt = T6;
            end
          end
          cls.br: begin
            s.rcOut = 1'b1; s.rzInLo = 1'b1;
            nxt = T6;
          end
          default: nxt = IDLE;
        endcase
      end
      T6: begin
        unique case (1'b1)
          cls.muldiv: begin
            s.rzOutHi = 1'b1; s.hiIn = 1'b1;
            nxt = endNxt;
          end
          cls.mem: begin
            if (op == OP_ST) begin
              s.gra = 1'b1; s.rOut = 1'b1; s.mdrIn = 1'b1;
              nxt = T7;
            end else begin
              s.mdrRead = 1'b1; s.mdrIn = 1'b1;
              if (memDone) nxt = T7;
            end
          end
          cls.br: begin
            s.rzOutLo = CON; s.pcIn = CON;
            nxt = endNxt;
          end
          default: nxt = IDLE;
        endcase
      end
      T7: begin
        if (op == OP_ST) begin
          s.ramWrite = 1'b1;
          if (memDone) nxt = endNxt;
        end else begin
          s.mdrOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1;
          nxt = endNxt;
        end
      end
      HALT: nxt = HALT;
`ifdef SINGLE_STEP_EN
      PAUSE: begin
        if (!run)          nxt = IDLE;
        else if (stepRise) nxt = T0;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  assign halted = (state == IDLE) | (state == HALT) | (state == PAUSE);

  assign PCout     = s.pcOut;
  assign PCin      = s.pcIn;
  assign IncPC     = s.incPc;
  assign MARin     = s.marIn;
  assign MDRin     = s.mdrIn;
  assign MDRout    = s.mdrOut;
  assign MDRread   = s.mdrRead;
  assign RAMwrite  = s.ramWrite;
  assign IRin      = s.irIn;
  assign RYin      = s.ryIn;
  assign RZinLo    = s.rzInLo;
  assign RZinHi    = s.rzInHi;
  assign RZoutLo   = s.rzOutLo;
  assign RZoutHi   = s.rzOutHi;
  assign HIin      = s.hiIn;
  assign LOin      = s.loIn;
  assign HIout     = s.hiOut;
  assign LOout     = s.loOut;
  assign Gra       = s.gra;
  assign Grb       = s.grb;
  assign Grc       = s.grc;
  assign Rin       = s.rIn;
  assign Rout      = s.rOut;
  assign BAout     = s.baOut;
  assign RCout     = s.rcOut;
  assign CONin     = s.conIn;
  assign InPortOut = s.inPortOut;
  assign OutPortIn = s.outPortIn;

endmodule
